// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module  : i2c_pkg
// Brief   : Shared constants for the I2C bus sampler: FSM encoding, byte
//           width and ACK/NACK line levels.
// Revision: 1.0 - initial release
// ============================================================================
package i2c_pkg;

  localparam logic [1:0] c_ST_IDLE       = 2'd0;
  localparam logic [1:0] c_ST_START_HOLD = 2'd1;
  localparam logic [1:0] c_ST_DATA       = 2'd2;
  localparam logic [1:0] c_ST_ACK        = 2'd3;

  localparam int unsigned c_BYTE_BITS   = 8;
  localparam logic [3:0]  c_BIT_CNT_MAX = 4'(c_BYTE_BITS);

  localparam logic c_ACK  = 1'b0;
  localparam logic c_NACK = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2c_sync_filter.sv
`default_nettype none
// ============================================================================
// Module  : i2c_sync_filter
// Brief   : Multi-flop synchronizer followed by a run-length glitch filter.
// Revision: 1.0 - initial release
// ============================================================================
module i2c_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst_,
  input  logic line_in,
  output logic line_filt
);

  localparam logic [3:0] c_FILT_LAST = 4'(FILT_LEN - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_filt;
  logic [3:0]             r_run;
  logic                   w_sync_out;
  logic                   w_differs;

  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_differs  = (w_sync_out != r_filt);

  // Flops come out of reset at the idle bus level so release makes no edge.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], line_in};
    end
  end

  // r_run counts consecutive samples disagreeing with the accepted level.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_filt <= 1'b1;
      r_run  <= '0;
    end else if (!w_differs) begin
      r_run  <= '0;
    end else if (r_run == c_FILT_LAST) begin
      r_filt <= w_sync_out;
      r_run  <= '0;
    end else begin
      r_run  <= r_run + 4'd1;
    end
  end

  assign line_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/i2c_bus_sampler.sv
`default_nettype none
// ============================================================================
// Module  : i2c_bus_sampler
// Brief   : Passive I2C bus monitor: detects START/STOP and captures data
//           and ACK bits on filtered SCL rising edges.
// Revision: 1.0 - initial release
// ============================================================================
module i2c_bus_sampler
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic       clk,
  input  logic       rst_,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       shift_en,
  output logic       shift_bit,
  output logic [3:0] bit_cnt,
  output logic       byte_done,
  output logic       ack_valid,
  output logic       ack_bit,
  output logic       start_det,
  output logic       stop_det,
  output logic       bus_busy
);

  logic w_scl;
  logic w_sda;
  logic r_scl_d;
  logic r_sda_d;

  i2c_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_scl_filter (
    .clk       (clk),
    .rst_      (rst_),
    .line_in   (scl_in),
    .line_filt (w_scl)
  );

  i2c_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_LEN    (FILT_LEN)
  ) u_sda_filter (
    .clk       (clk),
    .rst_      (rst_),
    .line_in   (sda_in),
    .line_filt (w_sda)
  );

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  logic w_scl_rise;
  logic w_scl_fall;
  logic w_start;
  logic w_stop;

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  // Requiring SCL high on both sides makes a simultaneous SCL edge data movement.
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_cnt;
  logic       r_shift_en;
  logic       r_shift_bit;
  logic [3:0] r_bit_cnt;
  logic       r_byte_done;
  logic       r_ack_valid;
  logic       r_ack_bit;
  logic       r_start_det;
  logic       r_stop_det;
  logic       r_busy;

  logic [3:0] w_cnt_nxt;
  logic       w_shift_en;
  logic       w_shift_bit;
  logic       w_byte_done;
  logic       w_ack_valid;
  logic       w_ack_bit;
  logic       w_start_det;
  logic       w_stop_det;
  logic       w_busy;

  // State and registered outputs; bit_cnt trails the internal count by a cycle.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state     <= c_ST_IDLE;
      r_cnt       <= '0;
      r_bit_cnt   <= '0;
      r_shift_en  <= 1'b0;
      r_shift_bit <= 1'b0;
      r_byte_done <= 1'b0;
      r_ack_valid <= 1'b0;
      r_ack_bit   <= c_NACK;
      r_start_det <= 1'b0;
      r_stop_det  <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit_cnt   <= r_cnt;
      r_shift_en  <= w_shift_en;
      r_shift_bit <= w_shift_bit;
      r_byte_done <= w_byte_done;
      r_ack_valid <= w_ack_valid;
      r_ack_bit   <= w_ack_bit;
      r_start_det <= w_start_det;
      r_stop_det  <= w_stop_det;
      r_busy      <= w_busy;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_stop) begin
      w_state_nxt = c_ST_IDLE;
    end else if (w_start) begin
      w_state_nxt = c_ST_START_HOLD;
    end else begin
      case (r_state)
        c_ST_START_HOLD: if (w_scl_fall) w_state_nxt = c_ST_DATA;
        c_ST_DATA:       if (w_scl_fall && (r_cnt == c_BIT_CNT_MAX)) w_state_nxt = c_ST_ACK;
        c_ST_ACK:        if (w_scl_fall) w_state_nxt = c_ST_DATA;
        default:         w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_shift_en  = 1'b0;
    w_shift_bit = r_shift_bit;
    w_byte_done = 1'b0;
    w_ack_valid = 1'b0;
    w_ack_bit   = r_ack_bit;
    w_start_det = 1'b0;
    w_stop_det  = 1'b0;
    w_busy      = r_busy;
    if (w_stop) begin
      w_stop_det = 1'b1;
      w_busy     = 1'b0;
      w_cnt_nxt  = '0;
    end else if (w_start) begin
      w_start_det = 1'b1;
      w_busy      = 1'b1;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        c_ST_START_HOLD: begin
          if (w_scl_fall) w_cnt_nxt = '0;
        end
        c_ST_DATA: begin
          // Saturate at a full byte; extra clocks before the ACK phase are ignored.
          if (w_scl_rise && (r_cnt < c_BIT_CNT_MAX)) begin
            w_shift_en  = 1'b1;
            w_shift_bit = w_sda;
            w_cnt_nxt   = r_cnt + 4'd1;
            w_byte_done = (r_cnt == (c_BIT_CNT_MAX - 4'd1));
          end
        end
        c_ST_ACK: begin
          if (w_scl_rise) begin
            w_ack_valid = 1'b1;
            w_ack_bit   = w_sda;
          end
          if (w_scl_fall) w_cnt_nxt = '0;
        end
        default: begin
          w_cnt_nxt = r_cnt;
        end
      endcase
    end
  end

  assign shift_en  = r_shift_en;
  assign shift_bit = r_shift_bit;
  assign bit_cnt   = r_bit_cnt;
  assign byte_done = r_byte_done;
  assign ack_valid = r_ack_valid;
  assign ack_bit   = r_ack_bit;
  assign start_det = r_start_det;
  assign stop_det  = r_stop_det;
  assign bus_busy  = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_sampler.sv
`default_nettype none
// ============================================================================
// Module  : tb_i2c_bus_sampler
// Brief   : Self-checking bench driving I2C pin sequences against a pin-level
//           protocol model that predicts the strobe event stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_i2c_bus_sampler;

  localparam int c_SYNC = 2;
  localparam int c_FILT = 3;
  localparam int c_LAT  = c_SYNC + c_FILT + 1;
  localparam int c_HOLD = 12;

  // Event codes: 100 START, 200 STOP, 300+10*bit+count SHIFT, 400 BYTE_DONE, 500+bit ACK
  localparam int c_M_IDLE = 0;
  localparam int c_M_HOLD = 1;
  localparam int c_M_DATA = 2;
  localparam int c_M_ACK  = 3;

  logic       clk    = 1'b0;
  logic       rst_   = 1'b0;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;
  logic       shift_en, shift_bit, byte_done, ack_valid, ack_bit;
  logic       start_det, stop_det, bus_busy;
  logic [3:0] bit_cnt;

  i2c_bus_sampler #(
    .SYNC_STAGES (c_SYNC),
    .FILT_LEN    (c_FILT)
  ) dut (
    .clk       (clk),
    .rst_      (rst_),
    .scl_in    (scl_in),
    .sda_in    (sda_in),
    .shift_en  (shift_en),
    .shift_bit (shift_bit),
    .bit_cnt   (bit_cnt),
    .byte_done (byte_done),
    .ack_valid (ack_valid),
    .ack_bit   (ack_bit),
    .start_det (start_det),
    .stop_det  (stop_det),
    .bus_busy  (bus_busy)
  );

  always #5 clk = ~clk;

  int    obs_q[$];
  int    exp_q[$];
  int    n_assert = 0;
  int    n_fail   = 0;
  string phase    = "reset";

  int    m_mode = c_M_IDLE;
  int    m_cnt  = 0;
  logic  m_busy = 1'b0;
  logic  m_ack  = 1'b1;

  logic  pend_sh  = 1'b0;
  logic  pend_bd  = 1'b0;
  logic  pend_bit = 1'b0;

  // Shift events carry the bit_cnt seen one cycle after the strobe.
  always @(negedge clk) begin
    if (!rst_) begin
      pend_sh <= 1'b0;
      pend_bd <= 1'b0;
    end else begin
      if (pend_sh) obs_q.push_back(300 + (pend_bit ? 10 : 0) + int'(bit_cnt));
      if (pend_bd) obs_q.push_back(400);
      if (start_det) obs_q.push_back(100);
      if (stop_det) obs_q.push_back(200);
      if (ack_valid) obs_q.push_back(500 + (ack_bit ? 1 : 0));
      pend_sh  <= shift_en;
      pend_bit <= shift_bit;
      pend_bd  <= byte_done;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_assert++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s/%s: observed %0d expected %0d", phase, tag, got, want);
    end
  endtask

  task automatic check_state();
    chk("event_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) chk("event", obs_q[i], exp_q[i]);
    obs_q.delete();
    exp_q.delete();
    chk("bus_busy", {31'd0, bus_busy}, {31'd0, m_busy});
    chk("bit_cnt", {28'd0, bit_cnt}, m_cnt);
    chk("ack_bit", {31'd0, ack_bit}, {31'd0, m_ack});
  endtask

  // Drive one settled pin state; the model derives the expected events from the transition.
  task automatic step(input logic s, input logic d);
    logic ps, pd;
    int   first;
    ps = scl_in;
    pd = sda_in;
    if (ps && s && pd && !d) begin
      exp_q.push_back(100);
      m_mode = c_M_HOLD; m_busy = 1'b1; m_cnt = 0;
    end else if (ps && s && !pd && d) begin
      exp_q.push_back(200);
      m_mode = c_M_IDLE; m_busy = 1'b0; m_cnt = 0;
    end else if (!ps && s) begin
      if (m_mode == c_M_DATA && m_cnt < 8) begin
        m_cnt++;
        exp_q.push_back(300 + (d ? 10 : 0) + m_cnt);
        if (m_cnt == 8) exp_q.push_back(400);
      end else if (m_mode == c_M_ACK) begin
        exp_q.push_back(500 + (d ? 1 : 0));
        m_ack = d;
      end
    end else if (ps && !s) begin
      if (m_mode == c_M_HOLD) begin
        m_mode = c_M_DATA; m_cnt = 0;
      end else if (m_mode == c_M_DATA && m_cnt == 8) begin
        m_mode = c_M_ACK;
      end else if (m_mode == c_M_ACK) begin
        m_mode = c_M_DATA; m_cnt = 0;
      end
    end
    @(negedge clk);
    scl_in = s;
    sda_in = d;
    first = 0;
    for (int i = 1; i <= c_HOLD; i++) begin
      @(posedge clk);
      #1;
      if (first == 0 && (start_det | stop_det | shift_en | ack_valid | byte_done)) first = i;
    end
    @(negedge clk);
    #1;
    if (exp_q.size() > 0) chk("latency", first, c_LAT);
    check_state();
  endtask

  task automatic send_bit(input logic b);
    step(1'b0, b);
    step(1'b1, b);
    step(1'b0, b);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_byte(input logic [7:0] v, input logic ack);
    send_bits(v, 8);
    send_bit(ack);
  endtask

  task automatic do_start();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic do_rstart();
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic do_stop();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_shift_en", {31'd0, shift_en}, 0);
    chk("rst_shift_bit", {31'd0, shift_bit}, 0);
    chk("rst_bit_cnt", {28'd0, bit_cnt}, 0);
    chk("rst_byte_done", {31'd0, byte_done}, 0);
    chk("rst_ack_valid", {31'd0, ack_valid}, 0);
    chk("rst_ack_bit", {31'd0, ack_bit}, 1);
    chk("rst_start_det", {31'd0, start_det}, 0);
    chk("rst_stop_det", {31'd0, stop_det}, 0);
    chk("rst_bus_busy", {31'd0, bus_busy}, 0);
  endtask

  task automatic settle_idle();
    repeat (c_HOLD) @(posedge clk);
    @(negedge clk);
    #1;
    check_state();
  endtask

  task automatic sda_glitch(input int len);
    @(negedge clk);
    sda_in = 1'b0;
    repeat (len) @(negedge clk);
    sda_in = 1'b1;
    settle_idle();
  endtask

  initial begin
    logic [7:0] v;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_ = 1'b1;
    settle_idle();

    phase = "byte_a5";
    do_start();
    send_byte(8'hA5, 1'b0);
    do_stop();

    phase = "glitch";
    sda_glitch(2);

    phase = "rep_start";
    do_start();
    send_bits(8'h0B, 4);
    do_rstart();
    send_byte(8'h3C, 1'b1);
    do_stop();

    phase = "stop_5bits";
    do_start();
    send_bits(8'h15, 5);
    do_stop();

    phase = "simul_idle";
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);

    phase = "simul_data";
    do_start();
    send_bit(1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    do_stop();

    phase = "reset_mid";
    do_start();
    send_bits(8'h05, 3);
    @(negedge clk);
    #2 rst_ = 1'b0;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst_ = 1'b1;
    m_mode = c_M_IDLE; m_cnt = 0; m_busy = 1'b0; m_ack = 1'b1;
    settle_idle();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, sda_in);
      step(1'b0, sda_in);
    end
    do_stop();

    phase = "random";
    for (int t = 0; t < 6; t++) begin
      if ($urandom_range(0, 1) == 1) sda_glitch($urandom_range(1, 2));
      do_start();
      for (int b = 0; b < int'($urandom_range(1, 3)); b++) begin
        v = 8'($urandom_range(0, 255));
        send_byte(v, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 1) == 1) begin
        v = 8'($urandom_range(0, 255));
        send_bits(v, $urandom_range(1, 7));
        do_rstart();
        v = 8'($urandom_range(0, 255));
        send_byte(v, 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 3) == 0) begin
        v = 8'($urandom_range(0, 255));
        send_bits(v, $urandom_range(1, 6));
      end
      do_stop();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire

// File: doc/i2c_bus_sampler.md
I2C_BUS_SAMPLER -- requirements
Module: i2c_bus_sampler

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops per bus line (legal 2..4).
REQ-002 Parameter FILT_LEN, default 3: consecutive equal samples needed to accept a line level (legal 1..15).
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst_  input  1  asynchronous, active-low reset.
REQ-005 scl_in  input  1  raw I2C SCL pin level, asynchronous to clk.
REQ-006 sda_in  input  1  raw I2C SDA pin level, asynchronous to clk.
REQ-007 shift_en  output  1  one-cycle strobe: one data bit captured.
REQ-008 shift_bit  output  1  captured SDA value; valid while shift_en=1.
REQ-009 bit_cnt  output  4  data bits captured in the current byte (0..8).
REQ-010 byte_done  output  1  one-cycle strobe: 8th bit of a byte captured.
REQ-011 ack_valid  output  1  one-cycle strobe: ACK/NACK bit sampled.
REQ-012 ack_bit  output  1  sampled ACK level (0=ACK, 1=NACK); holds until next ack_valid.
REQ-013 start_det  output  1  one-cycle strobe: START or repeated START detected.
REQ-014 stop_det  output  1  one-cycle strobe: STOP detected.
REQ-015 bus_busy  output  1  high from START until STOP.

Function
REQ-016 Each line passes through SYNC_STAGES flops, then a filter whose output changes only after FILT_LEN consecutive identical synchronized samples.
REQ-017 Edges are detected on filtered levels; every strobe output is registered, with fixed latency SYNC_STAGES+FILT_LEN+1 clk cycles from the first clk edge sampling the new pin level.
REQ-018 START = filtered SDA falls while filtered SCL is high in both the current and previous cycle; STOP = same with SDA rising.
REQ-019 SCL and SDA filtered edges in the same cycle are treated as data movement: no start_det/stop_det.
REQ-020 FSM states: IDLE, START_HOLD, DATA, ACK.
REQ-021 IDLE: on START -> START_HOLD, bus_busy=1; SCL edges ignored.
REQ-022 START_HOLD: on SCL falling -> DATA with bit_cnt=0.
REQ-023 DATA: on each SCL rising, shift_en=1, shift_bit=filtered SDA, bit_cnt+1; bits are MSB first.
REQ-024 DATA: byte_done pulses in the same cycle as the 8th shift_en; bit_cnt reads 8 from the following cycle; next SCL falling -> ACK.
REQ-025 ACK: on SCL rising, ack_bit=filtered SDA and ack_valid=1; shift_en not asserted; next SCL falling -> DATA, bit_cnt=0.
REQ-026 START in any non-IDLE state (repeated START): start_det=1, bit_cnt=0, -> START_HOLD, bus_busy stays 1.
REQ-027 STOP in any state: stop_det=1, bus_busy=0, bit_cnt=0, -> IDLE; a partial byte is discarded with no byte_done.
REQ-028 start_det/stop_det take priority over shift_en in the same cycle; at most one of shift_en, ack_valid asserts per cycle.
REQ-029 bit_cnt never exceeds 8; no wrap to 0 except via REQ-025/026/027.

Reset
REQ-030 rst_ low asynchronously clears: FSM=IDLE, all strobes 0, shift_bit=0, bit_cnt=0, ack_bit=1, bus_busy=0.
REQ-031 Synchronizer and filter flops reset to 1 (idle bus level), so release of reset with idle pins generates no edge.
REQ-032 Reset asserted mid-byte abandons the transfer; after release the block waits in IDLE for a fresh START.

Structure
REQ-033 Shared package i2c_pkg holds the FSM state encoding, the byte width constant (8) and the ACK/NACK level constants.
REQ-034 One sub-module i2c_sync_filter (synchronizer + FILT_LEN filter, parameters SYNC_STAGES, FILT_LEN), instantiated once for SCL and once for SDA.

Verification
REQ-035 START, byte 0xA5, ACK=0, STOP -> shift_en x8 with bits 1,0,1,0,0,1,0,1; one byte_done on the 8th shift_en; ack_valid with ack_bit=0; stop_det; bus_busy 1->0.
REQ-036 With FILT_LEN=3, 2-cycle SDA low glitch while SCL is high and the bus is idle -> no start_det, bus_busy stays 0.
REQ-037 START, 4 data bits, repeated START, byte 0x3C -> start_det twice, bit_cnt back to 0, bus_busy held 1, exactly one byte_done.
REQ-038 STOP after 5 bits -> stop_det, FSM IDLE, bit_cnt=0, no byte_done.
REQ-039 SCL rising and SDA falling in the same filtered cycle -> no start_det; shift_en only if in DATA.
REQ-040 rst_ pulsed low after 3 bits -> all outputs at reset values immediately; subsequent SCL toggles produce no shift_en until a new START.
